// File: rtl/dyn_add_ctrl.sv
// Adder front-end that models a variable-latency carry chain: the sum is computed at once, but
// the result is released only after a delay set by the longest carry-propagate run in A^B.
module dyn_add_ctrl #(
    parameter int unsigned N              = 32,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          Cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  S,
    output logic          Cout,
    output logic [7:0]    lat,
    output logic [31:0]   total_lat,
    output logic [31:0]   op_count
);

    localparam int unsigned ShAmt = $clog2(BITS_PER_CYCLE);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    k_q, k_d;
    logic [N-1:0]  s_q, s_d;
    logic          cout_q, cout_d;
    logic [7:0]    lat_q, lat_d;
    logic [31:0]   total_lat_q, total_lat_d;
    logic [31:0]   op_count_q, op_count_d;

    logic [N-1:0]  prop;
    logic [7:0]    run;
    logic [7:0]    max_run;
    logic [7:0]    k_load;
    logic [N:0]    sum;
    logic [32:0]   total_sum;

    // Longest run of propagate bits, i.e. the worst-case ripple distance of the carry.
    always_comb begin
        prop    = A ^ B;
        run     = '0;
        max_run = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (prop[i]) begin
                run = run + 8'd1;
            end else begin
                run = '0;
            end
            if (run > max_run) begin
                max_run = run;
            end
        end
        k_load = max_run >> ShAmt;
    end

    always_comb begin
        sum       = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
        total_sum = {1'b0, total_lat_q} + {25'd0, lat_q};
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        cout_d      = cout_q;
        lat_d       = lat_q;
        total_lat_d = total_lat_q;
        op_count_d  = op_count_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = sum[N-1:0];
                    cout_d  = sum[N];
                    k_d     = k_load;
                    lat_d   = k_load + 8'd1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (k_q != 8'd0) begin
                    k_d = k_q - 8'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    op_count_d  = op_count_q + 32'd1;
                    total_lat_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            lat_q       <= '0;
            total_lat_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            lat_q       <= lat_d;
            total_lat_q <= total_lat_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        S         = s_q;
        Cout      = cout_q;
        lat       = lat_q;
        total_lat = total_lat_q;
        op_count  = op_count_q;
    end

endmodule

// File: tb/tb_dyn_add_ctrl.sv
// Self-checking bench for dyn_add_ctrl: directed vector table, hand-written backpressure and
// reset sequences, then randomized operations checked against an arithmetic reference model.
module tb_dyn_add_ctrl;

    localparam int unsigned N   = 32;
    localparam int unsigned Bpc = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Cout;
    logic [7:0]  lat;
    logic [31:0] total_lat;
    logic [31:0] op_count;

    always #5 clk = ~clk;

    dyn_add_ctrl #(
        .N              (N),
        .BITS_PER_CYCLE (Bpc)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .lat       (lat),
        .total_lat (total_lat),
        .op_count  (op_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        cout;
        logic [7:0]  lat;
    } vec_t;

    vec_t        vecs[12];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ops;
    logic [31:0] exp_total;
    logic [31:0] held_s;
    logic [7:0]  held_lat;
    logic [7:0]  bp_lat;
    int          seen;
    int          n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Each AND with itself shifted right shortens every run of ones by one bit.
    function automatic int model_run(input logic [31:0] p);
        logic [31:0] x;
        int          l;
        x = p;
        l = 0;
        while (x != 32'd0) begin
            x = x & (x >> 1);
            l++;
        end
        return l;
    endfunction

    function automatic logic [7:0] model_lat(input logic [31:0] a, input logic [31:0] b);
        return 8'(1 + model_run(a ^ b) / int'(Bpc));
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] t, input logic [7:0] l);
        longint unsigned v;
        v = longint'(t) + longint'(l);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise();
        in_valid = 1'($urandom_range(0, 1));
        A        = $urandom;
        B        = $urandom;
        Cin      = 1'($urandom_range(0, 1));
    endtask

    // One full operation: accept, count edges to out_valid, handshake with random stalls.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input int stall_pct, input bit noise);
        logic [32:0] exp_sum;
        logic [7:0]  exp_lat;
        bit          hs;
        int          cnt;
        exp_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        exp_lat = model_lat(a, b);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        A         = a;
        B         = b;
        Cin       = cin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 300) begin
            if (noise) drive_noise();
            tick();
            cnt++;
        end
        check("latency_edges", 32'(cnt), 32'(exp_lat));
        check("sum", S, exp_sum[31:0]);
        check("cout", 32'(Cout), 32'(exp_sum[32]));
        check("lat", 32'(lat), 32'(exp_lat));
        cnt = 0;
        do begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            hs        = out_ready && out_valid;
            if (noise) drive_noise();
            tick();
            cnt++;
        end while (!hs && cnt < 200);
        check("handshake_seen", 32'(hs), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_ops   = exp_ops + 32'd1;
        exp_total = sat_add(exp_total, exp_lat);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("sum_held_after_hs", S, exp_sum[31:0]);
        check("op_count", op_count, exp_ops);
        check("total_lat", total_lat, exp_total);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 8'd1};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 8'd5};
        vecs[2]  = '{32'h0000_00FF, 32'h0000_0000, 1'b0, 32'h0000_00FF, 1'b0, 8'd2};
        vecs[3]  = '{32'h0000_007F, 32'h0000_0000, 1'b0, 32'h0000_007F, 1'b0, 8'd1};
        vecs[4]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 8'd1};
        vecs[5]  = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'd5};
        vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 8'd1};
        vecs[7]  = '{32'h00FF_FF00, 32'h0000_0000, 1'b0, 32'h00FF_FF00, 1'b0, 8'd3};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 8'd4};
        vecs[9]  = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 8'd5};
        vecs[10] = '{32'hF0F0_F0F0, 32'h0000_0000, 1'b0, 32'hF0F0_F0F0, 1'b0, 8'd1};
        vecs[11] = '{32'h00FF_00FF, 32'h0000_00FF, 1'b0, 32'h00FF_01FE, 1'b0, 8'd2};

        // Reset with in_valid high: reset must win, nothing captured.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        A         = 32'h1234_5678;
        B         = 32'h0F0F_0F0F;
        Cin       = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", S, 32'd0);
        check("rst_Cout", 32'(Cout), 32'd0);
        check("rst_lat", 32'(lat), 32'd0);
        check("rst_total_lat", total_lat, 32'd0);
        check("rst_op_count", op_count, 32'd0);
        exp_ops   = 32'd0;
        exp_total = 32'd0;

        // Directed table; expected sums and latencies are hand-derived.
        for (int i = 0; i < 12; i++) begin
            check("vec_model_lat", 32'(model_lat(vecs[i].a, vecs[i].b)), 32'(vecs[i].lat));
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0);
            check("vec_S", S, vecs[i].s);
            check("vec_Cout", 32'(Cout), 32'(vecs[i].cout));
            check("vec_lat", 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure in DONE with new operands offered throughout.
        A        = 32'h0F0F_0000;
        B        = 32'h00F0_FFFF;
        Cin      = 1'b0;
        bp_lat   = model_lat(A, B);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'(bp_lat));
        check("bp_S", S, 32'h0FFF_FFFF);
        held_s   = S;
        held_lat = lat;
        for (int c = 0; c < 10; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            A         = $urandom;
            B         = $urandom;
            tick();
            check("bp_S_stable", S, held_s);
            check("bp_lat_stable", 32'(lat), 32'(held_lat));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_op_count", op_count, exp_ops);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_ops   = exp_ops + 32'd1;
        exp_total = sat_add(exp_total, bp_lat);
        check("bp_op_count_after", op_count, exp_ops);
        check("bp_total_after", total_lat, exp_total);
        check("bp_no_same_cycle_accept", 32'(in_ready), 32'd1);
        check("bp_S_after", S, held_s);

        // Reset in the middle of WAIT of a 5-cycle operation.
        A        = 32'hFFFF_FFFF;
        B        = 32'h0000_0000;
        Cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_wait_busy", 32'(in_ready), 32'd0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrst_in_ready", 32'(in_ready), 32'd1);
        check("wrst_S", S, 32'd0);
        check("wrst_Cout", 32'(Cout), 32'd0);
        check("wrst_lat", 32'(lat), 32'd0);
        check("wrst_total", total_lat, 32'd0);
        check("wrst_op_count", op_count, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("wrst_out_valid_never", 32'(seen), 32'd0);
        exp_ops   = 32'd0;
        exp_total = 32'd0;
        run_op(32'd1, 32'd1, 1'b0, 0, 1'b0);
        check("wrst_next_S", S, 32'd2);
        check("wrst_next_lat", 32'(lat), 32'd1);

        // Randomized operations with output stalls and ignored in_valid noise.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ~ra & $urandom;
                1: rb = ra ^ (32'hFFFF_FFFF >> $urandom_range(0, 31));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 30, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
